// File: rtl/upc_loop_event_tracker_if.sv
// -----------------------------------------------------------------------------
// upc_loop_event_tracker_if
//   Record stream from the loop event tracker to the sample manager / csv
//   dumper stage. Plain valid/ready handshake; the payload is only meaningful
//   while rec_valid is high.
//
//   rec_valid  record available (driven by master)
//   rec_ready  consumer accepts record (driven by slave)
//   rec_type   0=LOOP_BEGIN, 1=ITER_END, 2=LOOP_END
//   rec_time   timestamp of the event
//   rec_iter   iterations completed in the current activation
//   rec_stall  start-stage stall cycles in the current activation
// -----------------------------------------------------------------------------
interface upc_loop_event_tracker_if #(
  parameter int TS_W  = 32,
  parameter int CNT_W = 32
) ();
  logic             rec_valid;
  logic             rec_ready;
  logic [1:0]       rec_type;
  logic [TS_W-1:0]  rec_time;
  logic [CNT_W-1:0] rec_iter;
  logic [CNT_W-1:0] rec_stall;

  modport master (
    output rec_valid, rec_type, rec_time, rec_iter, rec_stall,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_type, rec_time, rec_iter, rec_stall,
    output rec_ready
  );
endinterface

// File: rtl/upc_loop_event_tracker.sv
// -----------------------------------------------------------------------------
// upc_loop_event_tracker
//   Cycle-level event extractor for one pipelined HLS loop. Watches the same
//   probes as the upc loop interface and emits timestamped LOOP_BEGIN /
//   ITER_END / LOOP_END records through a first-word-fall-through FIFO.
//
//   clock              monitor clock
//   reset              asynchronous active-high reset
//   cur_state          loop FSM current state
//   iter_start_state   one-hot state that starts an iteration
//   iter_end_state     one-hot state that ends an iteration
//   iter_start_block   stall of the start stage
//   iter_end_block     stall of the end stage
//   iter_start_enable  pipeline enable of the first iteration stage
//   iter_end_enable    pipeline enable of the last iteration stage
//   loop_start         loop ap_start
//   loop_done          loop ap_done_int
//   loop_continue      loop ap_continue
//   finish             simulation end request (terminal until reset)
//   rec                record stream (master side)
//   overflow           sticky: at least one record dropped
//   busy               tracker active, LOOP_BEGIN pending, or FIFO not empty
// -----------------------------------------------------------------------------
module upc_loop_event_tracker #(
  parameter int STATE_W    = 16,
  parameter int TS_W       = 32,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [STATE_W-1:0]       cur_state,
  input  logic [STATE_W-1:0]       iter_start_state,
  input  logic [STATE_W-1:0]       iter_end_state,
  input  logic                     iter_start_block,
  input  logic                     iter_end_block,
  input  logic                     iter_start_enable,
  input  logic                     iter_end_enable,
  input  logic                     loop_start,
  input  logic                     loop_done,
  input  logic                     loop_continue,
  input  logic                     finish,
  upc_loop_event_tracker_if.master rec,
  output logic                     overflow,
  output logic                     busy
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_FINISHED
  } state_t;

  typedef enum logic [1:0] {
    REC_LOOP_BEGIN = 2'd0,
    REC_ITER_END   = 2'd1,
    REC_LOOP_END   = 2'd2
  } rec_type_e;

  typedef struct packed {
    rec_type_e        typ;
    logic [TS_W-1:0]  ts;
    logic [CNT_W-1:0] iter;
    logic [CNT_W-1:0] stall;
  } rec_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Probe qualifiers
  // ---------------------------------------------------------------------------
  logic hit_end;
  logic stall_hit;
  logic loop_end_req;

  assign hit_end      = (cur_state == iter_end_state) & ~iter_end_block & iter_end_enable;
  assign stall_hit    = (cur_state == iter_start_state) & iter_start_block;
  assign loop_end_req = loop_done & loop_continue;

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  state_t           state, state_nxt;
  logic [TS_W-1:0]  ts;
  logic [CNT_W-1:0] iter_cnt, iter_nxt;
  logic [CNT_W-1:0] stall_cnt, stall_nxt;

  logic             ev_valid;
  rec_t             ev_rec;
  logic             pend_set;
  logic             pend_valid;
  logic [TS_W-1:0]  pend_ts;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state plus the single event this edge produces.
  // NOTE: every signal written here gets a default first, so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    state_nxt = state;
    ev_valid  = 1'b0;
    ev_rec    = '0;
    pend_set  = 1'b0;
    iter_nxt  = iter_cnt;
    stall_nxt = stall_cnt;

    unique case (state)
      S_IDLE: begin
        if (loop_start) begin
          state_nxt    = S_ACTIVE;
          iter_nxt     = '0;
          stall_nxt    = '0;
          ev_valid     = 1'b1;
          ev_rec.typ   = REC_LOOP_BEGIN;
          ev_rec.ts    = ts;
        end
      end

      S_ACTIVE: begin
        if (hit_end)   iter_nxt  = sat_inc(iter_cnt);
        if (stall_hit) stall_nxt = sat_inc(stall_cnt);

        if (loop_end_req) begin
          // A coincident hit_end is already folded into iter_nxt.
          ev_valid     = 1'b1;
          ev_rec.typ   = REC_LOOP_END;
          ev_rec.ts    = ts;
          ev_rec.iter  = iter_nxt;
          ev_rec.stall = stall_nxt;
          if (loop_start) begin
            // Back-to-back activation: LOOP_BEGIN is parked for one cycle and
            // the new activation counts from zero starting next edge.
            pend_set  = 1'b1;
            iter_nxt  = '0;
            stall_nxt = '0;
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (hit_end) begin
          ev_valid     = 1'b1;
          ev_rec.typ   = REC_ITER_END;
          ev_rec.ts    = ts;
          ev_rec.iter  = iter_nxt;
          ev_rec.stall = stall_nxt;
        end
      end

      default: ; // S_FINISHED: ignore all probes
    endcase

    // The event of this same edge is still recorded above.
    if (finish) state_nxt = S_FINISHED;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts         <= '0;
      iter_cnt   <= '0;
      stall_cnt  <= '0;
      pend_valid <= 1'b0;
      pend_ts    <= '0;
    end else begin
      ts         <= ts + 1'b1;
      iter_cnt   <= iter_nxt;
      stall_cnt  <= stall_nxt;
      pend_valid <= pend_set;
      if (pend_set) pend_ts <= ts;
    end
  end

  // ---------------------------------------------------------------------------
  // Push arbitration: the parked LOOP_BEGIN beats any new event.
  // ---------------------------------------------------------------------------
  rec_t     push_rec;
  logic     push_req;
  logic     ev_lost;
  logic     fifo_full;
  logic     fifo_nonempty;
  logic     pop;
  logic     do_push;
  logic     push_drop;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  always_comb begin
    push_rec = ev_rec;
    if (pend_valid) begin
      push_rec       = '0;
      push_rec.typ   = REC_LOOP_BEGIN;
      push_rec.ts    = pend_ts;
    end
  end

  assign push_req      = pend_valid | ev_valid;
  assign ev_lost       = pend_valid & ev_valid;
  assign fifo_full     = (count == DEPTH_C);
  assign fifo_nonempty = (count != '0);
  assign pop           = fifo_nonempty & rec.rec_ready;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign do_push       = push_req & (~fifo_full | pop);
  assign push_drop     = push_req & fifo_full & ~pop;

  // ---------------------------------------------------------------------------
  // Record FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  rec_t mem [FIFO_DEPTH];

  // NOTE: the storage array has no reset; it is only observed through the
  // valid-gated outputs below, so stale contents are never visible.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_rec;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (ev_lost | push_drop) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: payload reads zero whenever no record is held.
  // ---------------------------------------------------------------------------
  rec_t head;
  assign head = mem[rd_ptr];

  assign rec.rec_valid = fifo_nonempty;
  assign rec.rec_type  = fifo_nonempty ? head.typ   : 2'b00;
  assign rec.rec_time  = fifo_nonempty ? head.ts    : '0;
  assign rec.rec_iter  = fifo_nonempty ? head.iter  : '0;
  assign rec.rec_stall = fifo_nonempty ? head.stall : '0;

  assign busy = (state == S_ACTIVE) | pend_valid | fifo_nonempty;

endmodule

// File: tb/tb_upc_loop_event_tracker.sv
module tb_upc_loop_event_tracker;

  localparam int          STATE_W  = 16;
  localparam int          TS_W     = 32;
  localparam int          CNT_W    = 32;
  localparam int          DEPTH    = 8;
  localparam logic [15:0] START_ST = 16'h0002;
  localparam logic [15:0] END_ST   = 16'h0008;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [STATE_W-1:0] cur_state = '0;
  logic [STATE_W-1:0] iter_start_state = START_ST;
  logic [STATE_W-1:0] iter_end_state = END_ST;
  logic iter_start_block = 1'b0, iter_end_block = 1'b0;
  logic iter_start_enable = 1'b0, iter_end_enable = 1'b0;
  logic loop_start = 1'b0, loop_done = 1'b0, loop_continue = 1'b0, finish = 1'b0;
  logic overflow, busy;

  upc_loop_event_tracker_if #(.TS_W(TS_W), .CNT_W(CNT_W)) rif ();

  upc_loop_event_tracker #(
    .STATE_W(STATE_W), .TS_W(TS_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .cur_state        (cur_state),
    .iter_start_state (iter_start_state),
    .iter_end_state   (iter_end_state),
    .iter_start_block (iter_start_block),
    .iter_end_block   (iter_end_block),
    .iter_start_enable(iter_start_enable),
    .iter_end_enable  (iter_end_enable),
    .loop_start       (loop_start),
    .loop_done        (loop_done),
    .loop_continue    (loop_continue),
    .finish           (finish),
    .rec              (rif),
    .overflow         (overflow),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a record queue plus the activation bookkeeping.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  typ;
    logic [31:0] ts;
    logic [31:0] iter;
    logic [31:0] stall;
  } rec_s;

  rec_s        exp_q[$];
  rec_s        got_q[$];
  bit          m_active, m_finished, m_pending, m_overflow;
  logic [31:0] m_ts, m_pend_ts, m_iter, m_stall;

  task automatic m_push(input rec_s r);
    if (exp_q.size() < DEPTH) exp_q.push_back(r);
    else m_overflow = 1'b1;
  endtask

  always @(posedge clock or posedge reset) begin : model
    bit   e_hit, e_stall, e_done, have_ev, pend_new, do_pop;
    rec_s ev;
    if (reset) begin
      exp_q.delete();
      m_active = 0; m_finished = 0; m_pending = 0; m_overflow = 0;
      m_ts = 0; m_pend_ts = 0; m_iter = 0; m_stall = 0;
    end else begin
      e_hit    = (cur_state == iter_end_state) && !iter_end_block && iter_end_enable;
      e_stall  = (cur_state == iter_start_state) && iter_start_block;
      e_done   = loop_done && loop_continue;
      have_ev  = 0;
      pend_new = 0;
      ev       = '{2'd0, 32'd0, 32'd0, 32'd0};
      do_pop   = (exp_q.size() != 0) && rif.rec_ready;
      if (!m_finished) begin
        if (!m_active) begin
          if (loop_start) begin
            m_active = 1; m_iter = 0; m_stall = 0;
            ev = '{2'd0, m_ts, 32'd0, 32'd0}; have_ev = 1;
          end
        end else begin
          if (e_hit && m_iter != 32'hFFFF_FFFF) m_iter++;
          if (e_stall && m_stall != 32'hFFFF_FFFF) m_stall++;
          if (e_done) begin
            ev = '{2'd2, m_ts, m_iter, m_stall}; have_ev = 1;
            if (loop_start) begin pend_new = 1; m_iter = 0; m_stall = 0; end
            else m_active = 0;
          end else if (e_hit) begin
            ev = '{2'd1, m_ts, m_iter, m_stall}; have_ev = 1;
          end
        end
        if (finish) begin m_finished = 1; m_active = 0; end
      end
      if (do_pop) void'(exp_q.pop_front());
      if (m_pending) begin
        if (have_ev) m_overflow = 1;
        m_push('{2'd0, m_pend_ts, 32'd0, 32'd0});
      end else if (have_ev) begin
        m_push(ev);
      end
      m_pending = pend_new;
      if (pend_new) m_pend_ts = m_ts;
      m_ts = m_ts + 1;
    end
  end

  // One compare process: every cycle outside reset.
  always @(negedge clock) begin
    if (!reset) begin
      check("rec_valid", rif.rec_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("rec_type",  rif.rec_type,  exp_q[0].typ);
        check("rec_time",  rif.rec_time,  exp_q[0].ts);
        check("rec_iter",  rif.rec_iter,  exp_q[0].iter);
        check("rec_stall", rif.rec_stall, exp_q[0].stall);
      end else begin
        check("idle_payload", {rif.rec_type, rif.rec_time, rif.rec_iter[29:0]}, 64'd0);
      end
      check("overflow", overflow, m_overflow);
      check("busy", busy, m_active || m_pending || exp_q.size() != 0);
      if (rif.rec_valid && rif.rec_ready)
        got_q.push_back('{rif.rec_type, rif.rec_time, rif.rec_iter, rif.rec_stall});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic goto_ts(input int t);
    int guard = 0;
    while (m_ts < t && guard < 1000) begin step(); guard++; end
    check("goto_ts", m_ts, t);
  endtask

  task automatic cyc(input logic [15:0] st, input logic sblk, input logic eblk,
                     input logic en, input logic ls, input logic ld, input logic fin);
    cur_state = st; iter_start_block = sblk; iter_end_block = eblk;
    iter_start_enable = en; iter_end_enable = en;
    loop_start = ls; loop_done = ld; loop_continue = ld; finish = fin;
    step();
    cur_state = '0; iter_start_block = 0; iter_end_block = 0;
    iter_start_enable = 0; iter_end_enable = 0;
    loop_start = 0; loop_done = 0; loop_continue = 0; finish = 0;
  endtask

  task automatic expect_rec(input string name, input int idx, input logic [1:0] typ,
                            input logic [31:0] ts, input logic [31:0] it, input logic [31:0] st);
    check({name, "_present"}, got_q.size() > idx, 1);
    if (got_q.size() > idx) begin
      check({name, "_type"},  got_q[idx].typ,   typ);
      check({name, "_time"},  got_q[idx].ts,    ts);
      check({name, "_iter"},  got_q[idx].iter,  it);
      check({name, "_stall"}, got_q[idx].stall, st);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int base;

  initial begin
    rif.rec_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Basic loop plus non-qualifying probe cycles.
    base = got_q.size();
    goto_ts(5);  cyc(16'h0, 0, 0, 1, 1, 0, 0);
    goto_ts(8);  cyc(END_ST, 0, 0, 1, 0, 0, 0);
    goto_ts(10); cyc(END_ST, 0, 0, 1, 0, 0, 0);
    goto_ts(12); cyc(END_ST, 0, 0, 1, 0, 0, 0);
    goto_ts(15); cyc(END_ST, 0, 0, 0, 0, 0, 0);   // enable low
    goto_ts(16); cyc(END_ST, 0, 1, 1, 0, 0, 0);   // end stage blocked
    goto_ts(18);
    loop_done = 1; loop_continue = 0; step();      // done without continue
    loop_done = 0;
    goto_ts(20); cyc(16'h0, 0, 0, 1, 0, 1, 0);
    repeat (3) step();
    check("basic_count", got_q.size() - base, 5);
    expect_rec("basic_begin", base + 0, 2'd0, 5, 0, 0);
    expect_rec("basic_iter1", base + 1, 2'd1, 8, 1, 0);
    expect_rec("basic_iter3", base + 3, 2'd1, 12, 3, 0);
    expect_rec("basic_end",   base + 4, 2'd2, 20, 3, 0);

    // Back-to-back activations.
    base = got_q.size();
    goto_ts(26); cyc(16'h0, 0, 0, 1, 1, 0, 0);
    goto_ts(30); cyc(16'h0, 0, 0, 1, 1, 1, 0);
    goto_ts(33); cyc(END_ST, 0, 0, 1, 0, 0, 0);
    goto_ts(35); cyc(16'h0, 0, 0, 1, 0, 1, 0);
    repeat (3) step();
    expect_rec("b2b_end",    base + 1, 2'd2, 30, 0, 0);
    expect_rec("b2b_begin",  base + 2, 2'd0, 30, 0, 0);
    expect_rec("b2b_iter",   base + 3, 2'd1, 33, 1, 0);
    expect_rec("b2b_end2",   base + 4, 2'd2, 35, 1, 0);

    // Start-stage stalls.
    base = got_q.size();
    goto_ts(40); cyc(16'h0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(START_ST, 1, 0, 1, 0, 0, 0);
    cyc(START_ST, 0, 0, 1, 0, 0, 0);
    goto_ts(47); cyc(16'h0, 0, 0, 1, 0, 1, 0);
    repeat (3) step();
    check("stall_count", got_q.size() - base, 2);
    expect_rec("stall_end", base + 1, 2'd2, 47, 0, 4);

    // Last iteration folded into LOOP_END.
    base = got_q.size();
    goto_ts(55); cyc(16'h0, 0, 0, 1, 1, 0, 0);
    goto_ts(57); cyc(END_ST, 0, 0, 1, 0, 0, 0);
    goto_ts(59); cyc(END_ST, 0, 0, 1, 0, 0, 0);
    goto_ts(61); cyc(END_ST, 0, 0, 1, 0, 1, 0);
    repeat (3) step();
    check("fold_count", got_q.size() - base, 4);
    expect_rec("fold_iter2", base + 2, 2'd1, 59, 2, 0);
    expect_rec("fold_end",   base + 3, 2'd2, 61, 3, 0);

    // Backpressure: 10 events into an 8-deep FIFO.
    rif.rec_ready = 0;
    goto_ts(70); cyc(16'h0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(END_ST, 0, 0, 1, 0, 0, 0);
    cyc(16'h0, 0, 0, 1, 0, 1, 0);
    repeat (3) step();
    check("bp_overflow", overflow, 1);
    check("bp_valid", rif.rec_valid, 1);
    base = got_q.size();
    rif.rec_ready = 1;
    repeat (12) step();
    check("bp_drained", got_q.size() - base, 8);
    expect_rec("bp_first", base + 0, 2'd0, 70, 0, 0);
    expect_rec("bp_last",  base + 7, 2'd1, 77, 7, 0);

    // Full FIFO with same-cycle pop and push: nothing lost.
    rif.rec_ready = 0;
    goto_ts(100); cyc(16'h0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 7; i++) cyc(END_ST, 0, 0, 1, 0, 0, 0);
    base = got_q.size();
    rif.rec_ready = 1;
    cyc(16'h0, 0, 0, 1, 0, 1, 0);
    rif.rec_ready = 0;
    step();
    check("full_pop_valid", rif.rec_valid, 1);
    rif.rec_ready = 1;
    repeat (12) step();
    check("full_pop_count", got_q.size() - base, 9);
    expect_rec("full_pop_end", base + 8, 2'd2, 108, 7, 0);

    // Reset mid-loop with three records queued.
    rif.rec_ready = 0;
    goto_ts(125); cyc(16'h0, 0, 0, 1, 1, 0, 0);
    cyc(END_ST, 0, 0, 1, 0, 0, 0);
    cyc(END_ST, 0, 0, 1, 0, 0, 0);
    step();
    check("pre_reset_busy", busy, 1);
    reset = 1;
    #1;
    check("rst_valid", rif.rec_valid, 0);
    check("rst_type",  rif.rec_type, 0);
    check("rst_time",  rif.rec_time, 0);
    check("rst_iter",  rif.rec_iter, 0);
    check("rst_stall", rif.rec_stall, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    step(); step();
    reset = 0;
    rif.rec_ready = 1;

    // Pending LOOP_BEGIN collides with ITER_END.
    base = got_q.size();
    goto_ts(2); cyc(16'h0, 0, 0, 1, 1, 0, 0);
    goto_ts(4); cyc(16'h0, 0, 0, 1, 1, 1, 0);
    cyc(END_ST, 0, 0, 1, 0, 0, 0);
    goto_ts(7); cyc(16'h0, 0, 0, 1, 0, 1, 0);
    repeat (3) step();
    check("coll_overflow", overflow, 1);
    check("coll_count", got_q.size() - base, 4);
    expect_rec("coll_begin", base + 2, 2'd0, 4, 0, 0);
    expect_rec("coll_end",   base + 3, 2'd2, 7, 1, 0);

    // Finish during a loop: same-cycle event kept, later ones ignored.
    rif.rec_ready = 0;
    goto_ts(15); cyc(16'h0, 0, 0, 1, 1, 0, 0);
    goto_ts(17); cyc(END_ST, 0, 0, 1, 0, 0, 0);
    goto_ts(19); cyc(END_ST, 0, 0, 1, 0, 0, 1);
    cyc(END_ST, 0, 0, 1, 0, 0, 0);
    cyc(16'h0, 0, 0, 1, 0, 1, 0);
    cyc(16'h0, 0, 0, 1, 1, 0, 0);
    step();
    check("fin_busy_full", busy, 1);
    base = got_q.size();
    rif.rec_ready = 1;
    repeat (8) step();
    check("fin_count", got_q.size() - base, 3);
    expect_rec("fin_last", base + 2, 2'd1, 19, 2, 0);
    check("fin_busy_drained", busy, 0);
    cyc(16'h0, 0, 0, 1, 1, 0, 0);
    repeat (3) step();
    check("fin_ignored", got_q.size() - base, 3);
    check("fin_busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
